// File: rtl/gpu_warp_convergence_unit_if.sv
// Decode/execute-side bundle for the warp convergence unit: barrier events in,
// active-mask and release/error status out.
interface gpu_warp_convergence_unit_if #(
  parameter int NUM_THREADS  = 32,
  parameter int NUM_BARRIERS = 8,
  parameter int BID_W        = 3
);
  logic                    add_valid;
  logic [BID_W-1:0]        add_id;
  logic [NUM_THREADS-1:0]  add_mask;
  logic                    arrive_valid;
  logic [BID_W-1:0]        arrive_id;
  logic [NUM_THREADS-1:0]  arrive_mask;
  logic                    exit_valid;
  logic [NUM_THREADS-1:0]  exit_mask;
  logic [NUM_THREADS-1:0]  active_mask;
  logic                    release_valid;
  logic [BID_W-1:0]        release_id;
  logic [NUM_THREADS-1:0]  release_mask;
  logic [NUM_BARRIERS-1:0] barrier_busy;
  logic                    err;

  modport master (
    output add_valid, add_id, add_mask,
    output arrive_valid, arrive_id, arrive_mask,
    output exit_valid, exit_mask,
    input  active_mask, release_valid, release_id, release_mask,
    input  barrier_busy, err
  );

  modport slave (
    input  add_valid, add_id, add_mask,
    input  arrive_valid, arrive_id, arrive_mask,
    input  exit_valid, exit_mask,
    output active_mask, release_valid, release_id, release_mask,
    output barrier_busy, err
  );
endinterface

// File: rtl/gpu_warp_convergence_unit.sv
// Convergence-barrier tracker for one SIMT warp: per-barrier participation and
// arrival masks, active-mask bookkeeping, and a lowest-index-first release arbiter.
module gpu_warp_convergence_unit #(
  parameter int NUM_THREADS  = 32,
  parameter int NUM_BARRIERS = 8,
  parameter int BID_W        = 3
) (
  input logic                     clk,
  input logic                     rst,
  gpu_warp_convergence_unit_if.slave bus
);
  localparam int NT = NUM_THREADS;
  localparam int NB = NUM_BARRIERS;

  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DONE = 2'd2} bar_state_t;

  logic [NT-1:0] active_reg, exited_reg;
  logic [NT-1:0] exit_eff, active_x, exited_next, rel_mask, legal_all;
  logic [NB-1:0] add_hit, arr_hit, done_vec, grant, bar_err, busy_vec;
  logic [NB-1:0][NT-1:0] arr_legal, rel_part;
  logic [BID_W-1:0] rel_id;
  logic oor;

  logic          rel_valid_reg;
  logic [BID_W-1:0] rel_id_reg;
  logic [NT-1:0] rel_mask_reg;
  logic          err_reg;

  assign exit_eff    = bus.exit_valid ? bus.exit_mask : '0;
  assign active_x    = active_reg & ~exit_eff;
  assign exited_next = exited_reg | exit_eff;
  // Isolate the lowest DONE barrier.
  assign grant       = done_vec & (~done_vec + NB'(1));

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_bar
      bar_state_t    state_reg;
      logic [NT-1:0] part_reg, arr_reg, part_x, arr_x, part_a, arr_a;
      logic          can_add, can_arr, complete;

      assign add_hit[gi] = bus.add_valid && (bus.add_id == BID_W'(gi));
      assign arr_hit[gi] = bus.arrive_valid && (bus.arrive_id == BID_W'(gi));

      // Event ordering inside one barrier: exit, then add, then arrive.
      assign part_x  = part_reg & ~exit_eff;
      assign arr_x   = arr_reg & ~exit_eff;
      assign can_add = add_hit[gi] && (state_reg != DONE);
      assign part_a  = can_add ? (part_x | bus.add_mask) : part_x;
      assign can_arr = arr_hit[gi] &&
                       ((state_reg == COLLECT) || ((state_reg == IDLE) && can_add));
      assign arr_legal[gi] = can_arr ? (bus.arrive_mask & part_a & active_x) : '0;
      assign arr_a    = arr_x | arr_legal[gi];
      assign complete = (part_a != '0) && (arr_a == part_a);

      assign bar_err[gi] = (add_hit[gi] && (state_reg == DONE)) ||
                           (arr_hit[gi] && !can_arr) ||
                           (can_arr && ((bus.arrive_mask & ~arr_legal[gi]) != '0));

      assign done_vec[gi] = (state_reg == DONE);
      assign busy_vec[gi] = (state_reg != IDLE);
      assign rel_part[gi] = grant[gi] ? part_x : '0;

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= IDLE;
          part_reg  <= '0;
          arr_reg   <= '0;
        end else begin
          case (state_reg)
            IDLE: begin
              part_reg <= part_a;
              arr_reg  <= arr_a;
              if (can_add) state_reg <= complete ? DONE : COLLECT;
            end
            COLLECT: begin
              part_reg <= part_a;
              arr_reg  <= arr_a;
              // Every participant exited: abandon without a release.
              if ((part_a == '0) && ((part_reg & exit_eff) != '0)) state_reg <= IDLE;
              else if (complete) state_reg <= DONE;
            end
            DONE: begin
              if (grant[gi]) begin
                state_reg <= IDLE;
                part_reg  <= '0;
                arr_reg   <= '0;
              end else begin
                part_reg <= part_x;
                arr_reg  <= arr_x;
              end
            end
            default: begin
              state_reg <= IDLE;
              part_reg  <= '0;
              arr_reg   <= '0;
            end
          endcase
        end
      end
    end
  endgenerate

  always_comb begin
    legal_all = '0;
    rel_mask  = '0;
    rel_id    = '0;
    for (int i = 0; i < NB; i++) begin
      legal_all = legal_all | arr_legal[i];
      rel_mask  = rel_mask | rel_part[i];
    end
    for (int i = NB - 1; i >= 0; i--) begin
      if (done_vec[i]) rel_id = BID_W'(i);
    end
    rel_mask = rel_mask & ~exited_next;
  end

  assign oor = (bus.add_valid && (add_hit == '0)) ||
               (bus.arrive_valid && (arr_hit == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      active_reg    <= '1;
      exited_reg    <= '0;
      rel_valid_reg <= 1'b0;
      rel_id_reg    <= '0;
      rel_mask_reg  <= '0;
      err_reg       <= 1'b0;
    end else begin
      active_reg    <= ((active_x & ~legal_all) | rel_mask) & ~exited_next;
      exited_reg    <= exited_next;
      rel_valid_reg <= (done_vec != '0);
      rel_id_reg    <= rel_id;
      rel_mask_reg  <= rel_mask;
      err_reg       <= (bar_err != '0) || oor;
    end
  end

  assign bus.active_mask   = active_reg;
  assign bus.release_valid = rel_valid_reg;
  assign bus.release_id    = rel_id_reg;
  assign bus.release_mask  = rel_mask_reg;
  assign bus.barrier_busy  = busy_vec;
  assign bus.err           = err_reg;
endmodule

// File: doc/gpu_warp_convergence_unit.md
Name: gpu_warp_convergence_unit

Overview:
- Parametrised convergence-barrier tracker for one SIMT warp.
- Holds NUM_BARRIERS independent barriers. Each barrier has a participation mask and an arrival (state) mask.
- Maintains the warp's active-thread mask and releases waiting threads once all participants have arrived.
- Sits beside the warp decode/execute stages. Decode issues BSSY/BSYNC/EXIT events; execute consumes active_mask.

Parameters:
- NUM_THREADS, 32, threads per warp (width of every mask).
- NUM_BARRIERS, 8, number of convergence barriers.
- BID_W, 3, barrier-id width; must equal clog2(NUM_BARRIERS).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- add_valid  in  1  BSSY: OR add_mask into the participation mask of barrier add_id
- add_id  in  BID_W  target barrier for BSSY
- add_mask  in  NUM_THREADS  threads joining
- arrive_valid  in  1  BSYNC: the threads in arrive_mask arrive at barrier arrive_id
- arrive_id  in  BID_W  target barrier for BSYNC
- arrive_mask  in  NUM_THREADS  threads arriving
- exit_valid  in  1  the threads in exit_mask terminate
- exit_mask  in  NUM_THREADS  threads exiting
- active_mask  out  NUM_THREADS  threads currently eligible to issue
- release_valid  out  1  one-cycle pulse: a barrier has released
- release_id  out  BID_W  barrier released
- release_mask  out  NUM_THREADS  threads returned to active_mask
- barrier_busy  out  NUM_BARRIERS  bit b = 1 while barrier b is not IDLE
- err  out  1  one-cycle pulse on an illegal event; the illegal part is ignored

Behaviour:
- Reset: all barriers IDLE, both masks zero, exited mask zero, active_mask all ones. release_valid = 0, release_id = 0, release_mask = 0, barrier_busy = 0, err = 0. Reset mid-collection discards all pending state.
- Per-barrier FSM has three states:
  - IDLE: add_valid moves the barrier to COLLECT with part = add_mask. An arrive in IDLE raises err and is ignored.
  - COLLECT: part |= add_mask; arr |= (arrive_mask & part). Go to DONE when the next-state part is nonzero and the next-state arr == part.
  - DONE: waits for the release arbiter. Any add or arrive to this barrier raises err and is ignored.
- Same-cycle ordering within one barrier: exit first, then add, then arrive, then completion check. An add and arrive in the same cycle to an IDLE barrier therefore behave as if the add came first.
- Exit handling:
  - Clears exit_mask bits from active_mask and from every barrier's part and arr.
  - Sets those bits in the exited mask; exited threads are never re-activated.
  - A COLLECT barrier left with part == 0 returns to IDLE with no release.
  - A barrier that completes because of an exit goes to DONE.
- Arrival handling:
  - Arriving bits are cleared from active_mask in the same edge, so active_mask updates on the next cycle.
  - Arrive bits that are not in part, or whose thread is already inactive, raise err and are dropped.
  - err still fires if only part of the arrive_mask was illegal.
- Release arbiter: each cycle, the lowest-index barrier in DONE is released.
  - On that edge: release_valid = 1, release_id = b, release_mask = part & ~exited.
  - Also on that edge: active_mask |= release_mask, the barrier returns to IDLE, and part/arr are cleared.
  - Latency: the final arrive accepted at edge N puts the barrier in DONE; release registers at edge N+1 if uncontested. Each further contending barrier adds one cycle.
- A barrier can be re-armed by add_valid in the cycle after its release.
- The valid inputs are independent and may all be asserted in one cycle, on the same or different barriers.
- active_mask never includes exited threads.
- Out-of-range ids (≥ NUM_BARRIERS) raise err and are ignored.

Test Plan:
- Basic convergence: add b2 mask 0x0000_00FF; arrive b2 0x0F, then 0xF0 → after the second arrive, active_mask = 0xFFFF_FF00; one cycle later release_valid = 1, release_id = 2, release_mask = 0xFF, active_mask = 0xFFFF_FFFF, barrier_busy[2] = 0.
- Contended release: complete b5 and b1 on the same edge → release b1 on the next cycle, then b5 on the following cycle; both pulses are one cycle wide.
- Exit completes barrier: add b0 0x3; arrive b0 0x1; exit 0x2 → release_mask = 0x1; active_mask bit 1 stays 0 forever.
- Errors: arrive on IDLE b3 → err = 1, state unchanged. In COLLECT with part 0x1, arrive 0x3 → err = 1, arr = 0x1, release follows.
- Same-cycle add+arrive on IDLE b4 with mask 0x1 → barrier enters DONE; released on the next cycle.
- Reset asserted with b6 in COLLECT and arr nonzero → next cycle barrier_busy = 0, active_mask = all ones, no release pulse.
